// File: rtl/clk_div_monitor_pkg.sv
// clk_div_monitor_pkg: shared state encoding and counter limit helper for clk_div_monitor.
package clk_div_monitor_pkg;
  typedef enum logic {IDLE, MEASURE} state_t;
  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction
endpackage

// File: rtl/clk_div_monitor_edge_det.sv
// edge_det: registers div_in and flags its rising and falling edges.
module edge_det (
  input  logic clk,
  input  logic reset,
  input  logic div_in,
  output logic rise,
  output logic fall
);
  logic div_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) div_q <= 1'b0;
    else div_q <= div_in;
  assign rise = div_in & ~div_q;
  assign fall = ~div_in & div_q;
endmodule

// File: rtl/clk_div_monitor.sv
// clk_div_monitor: measures period/high time of div_in, raises locked, sticky err and timeout.
module clk_div_monitor
  import clk_div_monitor_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int EXP_PERIOD = 6,
  parameter int EXP_HIGH   = 3,
  parameter int LOCK_COUNT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_in,
  input  logic             err_clr,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             err,
  output logic             timeout
);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] MAX = CNT_W'(cnt_max(CNT_W));
  localparam logic [CNT_W-1:0] EXP_P = CNT_W'(EXP_PERIOD);
  localparam logic [CNT_W-1:0] EXP_H = CNT_W'(EXP_HIGH);
  localparam logic [MW-1:0] LOCK_MAX = MW'(LOCK_COUNT);
  logic rise, fall;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc, hi_lat, hi_lat_n, period_n, high_n;
  logic [MW-1:0] match_cnt, match_n;
  logic mv_n, locked_n, err_n, to_n, err_set;
  edge_det u_edge (.clk(clk), .reset(reset), .div_in(div_in), .rise(rise), .fall(fall));
  assign cnt_inc = cnt + CNT_W'(1);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      hi_lat     <= '0;
      match_cnt  <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      err        <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      hi_lat     <= hi_lat_n;
      match_cnt  <= match_n;
      period     <= period_n;
      high_time  <= high_n;
      meas_valid <= mv_n;
      locked     <= locked_n;
      err        <= err_n;
      timeout    <= to_n;
    end
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    hi_lat_n = hi_lat;
    match_n  = match_cnt;
    period_n = period;
    high_n   = high_time;
    mv_n     = 1'b0;
    locked_n = locked;
    to_n     = 1'b0;
    err_set  = 1'b0;
    if (state == IDLE) begin
      cnt_n   = '0;
      state_n = rise ? MEASURE : IDLE;
    end else if (rise) begin
      period_n = cnt_inc;
      high_n   = hi_lat;
      mv_n     = 1'b1;
      cnt_n    = '0;
      if (cnt_inc == EXP_P && hi_lat == EXP_H) begin
        match_n  = (match_cnt == LOCK_MAX) ? match_cnt : match_cnt + MW'(1);
        locked_n = (match_n == LOCK_MAX);
      end else begin
        match_n  = '0;
        locked_n = 1'b0;
        err_set  = 1'b1;
      end
    end else begin
      cnt_n    = (cnt == MAX) ? cnt : cnt_inc;
      hi_lat_n = fall ? cnt_inc : hi_lat;
      // Saturating here means no rise arrived in time; drop back and rearm.
      if (cnt_n == MAX) begin
        to_n     = 1'b1;
        err_set  = 1'b1;
        locked_n = 1'b0;
        match_n  = '0;
        state_n  = IDLE;
        cnt_n    = '0;
      end
    end
    err_n = err_set | (err & ~err_clr);
  end
endmodule
